// File: rtl/gvram_pixel_serializer.sv
// gvram_pixel_serializer
//   Graphic VRAM fetch, serializer and CPU/display bus arbiter (MZ-80B).
//   Each 8-dot byte slot is timed by CNT: the display read strobe nVRD
//   covers phases RD_START..RD_LATCH, the byte is captured on the RD_LATCH
//   edge, loaded into the shifter on the CNT==7 edge and shifted out one
//   dot per CLK during the following byte slot.
//
// Ports
//   CLK      in   dot clock (16 MHz)
//   RST      in   synchronous reset, active high
//   CNT      in   byte phase 0..7, advances by one per CLK
//   nHBLANK  in   low during horizontal blank
//   nVBLANK  in   low during vertical blank
//   DB       in   VRAM read data
//   GEN      in   graphic plane enable
//   RVS      in   reverse video
//   CPU_REQ  in   CPU requests the VRAM bus (level)
//   nVRD     out  display read strobe, active low
//   CPU_ACK  out  CPU owns the VRAM bus
//   nWAIT    out  CPU wait, active low
//   GDOT     out  serial graphic dot
module gvram_pixel_serializer #(
    parameter logic [2:0] RD_START  = 3'd2,
    parameter logic [2:0] RD_LATCH  = 3'd5,
    parameter logic       MSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] CNT,
    input  logic       nHBLANK,
    input  logic       nVBLANK,
    input  logic [7:0] DB,
    input  logic       GEN,
    input  logic       RVS,
    input  logic       CPU_REQ,
    output logic       nVRD,
    output logic       CPU_ACK,
    output logic       nWAIT,
    output logic       GDOT
);

    // Edges on which the registered strobe is driven low: one phase ahead
    // of the window in which nVRD is observed low.
    localparam logic [2:0] RD_PRE  = RD_START - 3'd1;
    localparam logic [2:0] RD_LAST = RD_LATCH - 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_CPU
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       vact;
    logic [7:0] hold;
    logic [7:0] sh;
    logic       sact;
    logic       sh_out;
    logic       fetch_win;
    logic       cpu_slot;
    logic       nvrd_nx;
    logic       ack_nx;

    // The whole fetch window (not only its first phase) both claims the bus
    // and evicts the CPU. With an incrementing CNT this is identical to
    // acting on CNT==RD_START-1 alone, and it keeps CPU_ACK and nVRD
    // mutually exclusive even if CNT jumps.
    assign fetch_win = vact && (CNT >= RD_PRE) && (CNT <= RD_LAST);
    assign cpu_slot  = ~vact || (CNT == 3'd6) || (CNT == 3'd7);

    // ---------------- arbitration FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            nVRD    <= 1'b1;
            CPU_ACK <= 1'b0;
        end else begin
            state   <= state_nx;
            nVRD    <= nvrd_nx;
            CPU_ACK <= ack_nx;
        end
    end

    // ---------------- arbitration FSM: next state ----------------
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (fetch_win)
                    state_nx = ST_VID;
                else if (CPU_REQ && cpu_slot)
                    state_nx = ST_CPU;
            end
            ST_VID: begin
                if (!fetch_win)
                    state_nx = ST_IDLE;
            end
            ST_CPU: begin
                if (fetch_win || !CPU_REQ)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ---------------- arbitration FSM: outputs ----------------
    always_comb begin
        nvrd_nx = ~fetch_win;
        ack_nx  = (state_nx == ST_CPU);
    end

    assign nWAIT = ~(CPU_REQ & ~CPU_ACK);

    // ---------------- fetch latch and dot shifter ----------------
    assign sh_out = MSB_FIRST ? sh[7] : sh[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            vact <= 1'b0;
            hold <= '0;
            sh   <= '0;
            sact <= 1'b0;
            GDOT <= 1'b0;
        end else begin
            if (CNT == 3'd0)
                vact <= nHBLANK & nVBLANK;

            if (CNT == RD_LATCH)
                hold <= vact ? DB : '0;

            if (CNT == 3'd7) begin
                sh   <= hold;
                sact <= vact;
            end else if (MSB_FIRST) begin
                sh <= {sh[6:0], 1'b0};
            end else begin
                sh <= {1'b0, sh[7:1]};
            end

            GDOT <= GEN & sact & (sh_out ^ RVS);
        end
    end

endmodule

// File: tb/tb_gvram_pixel_serializer.sv
// tb_gvram_pixel_serializer
//   Drives randomized and directed byte slots into gvram_pixel_serializer.
//   A reference model works in terms of byte slots: the byte fetched in one
//   slot is shown as dot k at phase k of the next slot; the CPU may hold the
//   bus outside the fetch window of active slots. Expected outputs for each
//   edge are queued and a negedge monitor pops and compares them.
module tb_gvram_pixel_serializer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] CNT;
    logic       nHBLANK;
    logic       nVBLANK;
    logic [7:0] DB;
    logic       GEN;
    logic       RVS;
    logic       CPU_REQ;
    logic       nVRD;
    logic       CPU_ACK;
    logic       nWAIT;
    logic       GDOT;

    gvram_pixel_serializer #(
        .RD_START (3'd2),
        .RD_LATCH (3'd5),
        .MSB_FIRST(1'b1)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CNT    (CNT),
        .nHBLANK(nHBLANK),
        .nVBLANK(nVBLANK),
        .DB     (DB),
        .GEN    (GEN),
        .RVS    (RVS),
        .CPU_REQ(CPU_REQ),
        .nVRD   (nVRD),
        .CPU_ACK(CPU_ACK),
        .nWAIT  (nWAIT),
        .GDOT   (GDOT)
    );

    initial forever #5 CLK = ~CLK;

    typedef struct packed {
        logic gdot;
        logic nvrd;
        logic ack;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pulses   = 0;
    int   cnt      = 0;

    logic g_nh  = 1'b1;
    logic g_nv  = 1'b1;
    logic g_gen = 1'b1;
    logic g_rvs = 1'b0;

    // reference model state, in byte-slot terms
    logic       m_vact      = 1'b0;  // current slot is an active-display slot
    logic [7:0] m_cur       = '0;    // byte fetched in the current slot
    logic       m_prev_vact = 1'b0;  // previous slot was active
    logic [7:0] m_prev      = '0;    // byte fetched in the previous slot
    logic       m_ack       = 1'b0;  // CPU currently granted

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Evaluate one clock edge using the inputs present at that edge.
    task automatic model_step();
        exp_t e;
        int   c;
        logic in_fetch;
        logic ack_n;
        if (RST) begin
            m_vact      = 1'b0;
            m_cur       = '0;
            m_prev_vact = 1'b0;
            m_prev      = '0;
            m_ack       = 1'b0;
            e.gdot      = 1'b0;
            e.nvrd      = 1'b1;
            e.ack       = 1'b0;
        end else begin
            c = int'(CNT);
            // CPU may hold/gain the bus unless the fetch of this active slot
            // is about to run; new grants only in blank or phases 6/7.
            in_fetch = m_vact && (c >= 1) && (c <= 4);
            ack_n = CPU_REQ && !in_fetch && (m_ack || !m_vact || c >= 6);
            if (c == 0) begin
                m_prev      = m_cur;
                m_prev_vact = m_vact;
                m_vact      = nHBLANK & nVBLANK;
            end
            if (c == 5)
                m_cur = m_vact ? DB : 8'h00;
            // strobe observed low at phases 2..5 of an active slot
            e.nvrd = !(m_vact && (c >= 1) && (c <= 4));
            e.gdot = GEN & m_prev_vact & (m_prev[7 - c] ^ RVS);
            e.ack  = ack_n;
            m_ack  = ack_n;
        end
        q.push_back(e);
    endtask

    task automatic tick(input logic rst, input logic req, input logic [7:0] db);
        RST     = rst;
        CNT     = 3'(cnt % 8);
        nHBLANK = g_nh;
        nVBLANK = g_nv;
        GEN     = g_gen;
        RVS     = g_rvs;
        CPU_REQ = req;
        DB      = db;
        @(posedge CLK);
        model_step();
        #1;
        cnt++;
    endtask

    task automatic run_random(input int n, input logic rand_req);
        for (int i = 0; i < n; i++)
            tick(1'b0, rand_req ? 1'($urandom) : 1'b0, 8'($urandom));
    endtask

    // monitor: compare every queued expectation, watch the bus invariant and
    // count strobe pulses
    initial begin
        exp_t e;
        logic prev_nvrd;
        prev_nvrd = 1'b1;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("gdot", GDOT, e.gdot);
                check("nvrd", nVRD, e.nvrd);
                check("cpu_ack", CPU_ACK, e.ack);
                check("nwait", nWAIT, ~(CPU_REQ & ~e.ack));
                check("ack_and_strobe", CPU_ACK & ~nVRD, 1'b0);
                if (prev_nvrd === 1'b1 && nVRD === 1'b0)
                    pulses++;
                prev_nvrd = nVRD;
            end
        end
    end

    initial begin
        int base;

        // reset held for one slot
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 8'h00);

        // fetch/serialize with DB=A5, then random bytes
        for (int i = 0; i < 32; i++) tick(1'b0, 1'b0, 8'hA5);
        run_random(24, 1'b0);

        // reverse video, plane disabled, horizontal blank
        g_rvs = 1'b1;
        for (int i = 0; i < 24; i++) tick(1'b0, 1'b0, 8'hA5);
        run_random(8, 1'b0);
        g_rvs = 1'b0;
        g_gen = 1'b0;
        run_random(16, 1'b0);
        g_gen = 1'b1;
        g_nh  = 1'b0;
        run_random(16, 1'b0);
        g_nh  = 1'b1;
        g_rvs = 1'b1;
        g_nh  = 1'b0;
        run_random(16, 1'b0);
        g_rvs = 1'b0;
        g_nh  = 1'b1;

        // CPU access during vertical blank
        g_nv = 1'b0;
        run_random(8, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'($urandom));
        run_random(24, 1'b1);

        // CPU access in active display: request from CNT 2, held across
        // the next fetch so it is preempted
        g_nv = 1'b1;
        run_random(16, 1'b0);
        for (int i = 0; i < 2; i++) tick(1'b0, 1'b0, 8'($urandom));
        for (int i = 0; i < 14; i++) tick(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 8'($urandom));

        // reset pulse at CNT 4 during a fetch, with the CPU waiting
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'($urandom));
        tick(1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom));
        run_random(32, 1'b1);

        // full 640-dot line with random CPU traffic
        g_nh = 1'b0;
        run_random(8, 1'b1);
        base = pulses;
        g_nh = 1'b1;
        run_random(640, 1'b1);
        g_nh = 1'b0;
        run_random(16, 1'b1);
        repeat (2) @(negedge CLK);
        #1;
        check("pulses_per_line", (pulses - base) == 80, 1'b1);
        if ((pulses - base) != 80)
            $display("FAIL pulse_count: got %0d, expected 80", pulses - base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
